adc_capture_fifo: RTL and testbench

//  - Front-end stage directly upstream of sindrv.
//  - Samples the adc_in pin bus, decimates by a power-of-two window and buffers results in a FIFO.
//  - Presents the buffered samples as a valid/ready stream to sindrv.
//  - Decouples the free-running ADC from sindrv's mdriver_int transaction rate, with overflow reporting.

---
 rtl/adc_cap_pkg.sv | 17 +
 rtl/adc_capture_fifo_sync_fifo.sv | 52 +++++
 rtl/adc_capture_fifo.sv | 97 +++++++++
 tb/tb_adc_capture_fifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// Shared constants, sample type and window helper for the ADC capture front end.
package adc_cap_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int DEPTH_DEF    = 16;
  localparam int DECIM_LOG2_W = 4;
  localparam int ACC_W        = DATA_W_DEF + 15;
  localparam int CNT_W        = 15;

  typedef logic [DATA_W_DEF-1:0] adc_sample_t;

  // Terminal count of a window of 2**w cycles.
  function automatic logic [CNT_W-1:0] window_last(input logic [DECIM_LOG2_W-1:0] w);
    logic [31:0] span;
    span = (32'd1 << w) - 32'd1;
    window_last = span[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/adc_capture_fifo_sync_fifo.sv
// Synchronous FIFO with a registered head output; a push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_next;
  logic              push_ok;
  logic              pop_ok;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    rd_next = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Head register looks ahead: a word written this cycle into the next head slot bypasses the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      dout <= (push_ok && (wr_ptr == rd_next)) ? din : mem[rd_next];
    end
  end
endmodule

// File: rtl/adc_capture_fifo.sv
// ADC capture: power-of-two decimation window feeding a valid/ready FIFO with sticky overflow.
// Build option ADC_AVG_EN pushes the window average instead of the last sample.
module adc_capture_fifo
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DECIM_LOG2_W-1:0]  decim_log2,
  input  logic [DATA_W-1:0]        adc_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  logic [CNT_W-1:0]        win_cnt_p0;
  logic [DECIM_LOG2_W-1:0] w_lat_p0;
  logic [DECIM_LOG2_W-1:0] w_eff;
  logic                    strobe;
  logic [DATA_W-1:0]       push_data;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic                    drop;

  // The window length is taken from decim_log2 only on the first cycle of a window.
  always_comb begin
    w_eff  = (win_cnt_p0 == '0) ? decim_log2 : w_lat_p0;
    strobe = enable && (win_cnt_p0 == window_last(w_eff));
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      win_cnt_p0 <= '0;
      if (reset) w_lat_p0 <= '0;
    end else begin
      if (win_cnt_p0 == '0) w_lat_p0 <= decim_log2;
      win_cnt_p0 <= strobe ? '0 : win_cnt_p0 + 1'b1;
    end
  end

`ifdef ADC_AVG_EN
  localparam int SUM_W = DATA_W + 15;

  logic [SUM_W-1:0] acc_p0;
  logic [SUM_W-1:0] sum;

  function automatic logic [DATA_W-1:0] avg_shift(input logic [SUM_W-1:0] s,
                                                  input logic [DECIM_LOG2_W-1:0] w);
    logic [SUM_W-1:0] q;
    q = s >> w;
    avg_shift = q[DATA_W-1:0];
  endfunction

  always_comb begin
    sum       = acc_p0 + {15'd0, adc_in};
    push_data = avg_shift(sum, w_eff);
  end

  always_ff @(posedge clk) begin
    if (reset || !enable || strobe) acc_p0 <= '0;
    else                            acc_p0 <= sum;
  end
`else
  always_comb push_data = adc_in;
`endif

  always_comb begin
    m_valid = !empty;
    pop     = m_valid && m_ready;
    drop    = strobe && full && !pop;
  end

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (strobe),
    .pop   (pop),
    .din   (push_data),
    .dout  (m_data),
    .count (fill_level),
    .full  (full),
    .empty (empty)
  );

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end
endmodule

// File: tb/tb_adc_capture_fifo.sv
// Self-checking bench for adc_capture_fifo: directed steps plus random traffic against a queue-based model.
module tb_adc_capture_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int FW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [3:0]        decim_log2;
  logic [DATA_W-1:0] adc_in;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [FW-1:0]     fill_level;
  logic              overflow;
  logic              clr_ovf;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] win_q[$];
  int          win_len = 1;
  bit          exp_ovf = 1'b0;

  always #5 clk = ~clk;

  adc_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .decim_log2 (decim_log2),
    .adc_in     (adc_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .fill_level (fill_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance the reference model by the same cycle, compare just after the edge.
  task automatic cyc(input bit rst, input bit en, input logic [3:0] dl,
                     input logic [31:0] adc, input bit rdy, input bit clr);
    bit          strobe;
    bit          pop;
    bit          drop;
    logic [31:0] val;
    longint      s;
    reset = rst; enable = en; decim_log2 = dl; adc_in = adc; m_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    strobe = 1'b0;
    val    = '0;
    if (rst) begin
      exp_q.delete();
      win_q.delete();
      exp_ovf = 1'b0;
    end else begin
      pop = (exp_q.size() != 0) && rdy;
      if (!en) begin
        win_q.delete();
      end else begin
        if (win_q.size() == 0) win_len = 1 << dl;
        win_q.push_back(adc);
        if (win_q.size() == win_len) begin
          strobe = 1'b1;
`ifdef ADC_AVG_EN
          s = 0;
          foreach (win_q[i]) s += longint'(win_q[i]);
          val = 32'(s / longint'(win_len));
`else
          s = 0;
          val = win_q[win_q.size()-1];
`endif
          win_q.delete();
        end
      end
      drop = strobe && (exp_q.size() == DEPTH) && !pop;
      if (pop) void'(exp_q.pop_front());
      if (strobe && !drop) exp_q.push_back(val);
      if (drop) exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
    end
    #1;
    check("m_valid", m_valid, exp_q.size() != 0);
    check("fill_level", fill_level, exp_q.size());
    check("overflow", overflow, exp_ovf);
    if (exp_q.size() != 0) check("m_data", m_data, exp_q[0]);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; decim_log2 = '0; adc_in = '0; m_ready = 1'b0; clr_ovf = 1'b0;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("reset_m_data", m_data, 0);
    check("reset_fill", fill_level, 0);

    // Strobe every cycle, ramp passes straight through one cycle later
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, i, 1, 0);
      check("ramp_data", m_data, i);
    end

    // Four-cycle window on 10,20,30,...
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 2, 10 * i, 0, 0);
`ifdef ADC_AVG_EN
    check("decim4_first", m_data, 25);
`else
    check("decim4_first", m_data, 40);
`endif
    for (int i = 5; i <= 8; i++) cyc(0, 1, 2, 10 * i, 0, 0);
    check("decim4_fill", fill_level, 2);

    // Fill to full, drop the 17th, then sustained push+pop at full
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, $urandom, 0, 0);
    check("full_fill", fill_level, 16);
    check("full_no_ovf", overflow, 0);
    cyc(0, 1, 0, $urandom, 0, 0);
    check("drop_ovf", overflow, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, $urandom, 1, 0);
    check("pushpop_fill", fill_level, 16);

    // clr_ovf against a drop, then alone
    cyc(0, 1, 0, $urandom, 0, 1);
    check("clr_vs_drop", overflow, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("clr_alone", overflow, 0);

    // Reset mid-window with five entries held
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, $urandom, 0, 0);
    check("pre_reset_fill", fill_level, 5);
    cyc(0, 1, 2, $urandom, 0, 0);
    cyc(1, 1, 2, $urandom, 0, 0);
    check("post_reset_valid", m_valid, 0);
    check("post_reset_fill", fill_level, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2, $urandom, 0, 0);
    check("no_early_strobe", fill_level, 0);
    cyc(0, 1, 2, $urandom, 0, 0);
    check("strobe_after_4", fill_level, 1);

    // Random traffic with mid-window decim changes, enable gaps and occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
          4'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 40; i++) cyc(0, 1, 3, $urandom, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
